// File: rtl/cache_bus_pkg.sv
// rtl/cache_bus_pkg.sv - shared types and constants for the cache bus arbiter
package cache_bus_pkg;

   // Requester identifiers, also the value stored in the read-return ID FIFO
   localparam logic PORT_S0 = 1'b0;
   localparam logic PORT_S1 = 1'b1;

   localparam int AV_ADDR_WIDTH = 32;
   localparam int AV_DATA_WIDTH = 32;
   localparam int AV_BE_WIDTH   = AV_DATA_WIDTH / 8;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } arb_state_t;

   // Occupancy counter must represent both 0 and DEPTH
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/cache_arb_id_fifo.sv
// rtl/cache_arb_id_fifo.sv - 1-bit in-order ID FIFO recording which port issued each pending read
module cache_arb_id_fifo
   import cache_bus_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rest,
   input  logic i_push,
   input  logic i_id,
   input  logic i_pop,
   output logic o_full,
   output logic o_empty,
   output logic o_head
);

   localparam int CW = cnt_width(DEPTH);
   localparam int PW = $clog2(DEPTH);

   logic          r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_push;
   logic w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

   // A pop on empty is a dropped beat; a push on full is only legal alongside a pop
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_id;
   end

endmodule

// File: rtl/cache_bus_arb.sv
// rtl/cache_bus_arb.sv - round-robin Avalon-MM arbiter sharing one memory master between I$ and D$
module cache_bus_arb
   import cache_bus_pkg::*;
#(
   parameter  int ADDR_WIDTH  = AV_ADDR_WIDTH,
   parameter  int DATA_WIDTH  = AV_DATA_WIDTH,
   parameter  int MAX_PENDING = 4,
   localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rest,

   input  logic [ADDR_WIDTH-1:0] s0_address,
   input  logic [BE_WIDTH-1:0]   s0_byteEnable,
   input  logic                  s0_read,
   input  logic                  s0_write,
   input  logic [DATA_WIDTH-1:0] s0_writeData,
   output logic                  s0_waitRequest,
   output logic [DATA_WIDTH-1:0] s0_readData,
   output logic                  s0_readDataValid,

   input  logic [ADDR_WIDTH-1:0] s1_address,
   input  logic [BE_WIDTH-1:0]   s1_byteEnable,
   input  logic                  s1_read,
   input  logic                  s1_write,
   input  logic [DATA_WIDTH-1:0] s1_writeData,
   output logic                  s1_waitRequest,
   output logic [DATA_WIDTH-1:0] s1_readData,
   output logic                  s1_readDataValid,

   output logic [ADDR_WIDTH-1:0] m0_address,
   output logic [BE_WIDTH-1:0]   m0_byteEnable,
   output logic                  m0_read,
   output logic                  m0_write,
   output logic [DATA_WIDTH-1:0] m0_writeData,
   input  logic                  m0_waitRequest,
   input  logic [DATA_WIDTH-1:0] m0_readData,
   input  logic                  m0_readDataValid
);

   arb_state_t r_state, w_state_nxt;
   logic       r_owner, w_owner_nxt;
   logic       r_prio,  w_prio_nxt;

   logic w_fifo_full;
   logic w_fifo_empty;
   logic w_fifo_head;

   logic w_cand0, w_cand1;
   logic w_sel;
   logic w_present;
   logic w_go;
   logic w_accept;
   logic w_stall;
   logic w_push;
   logic w_pop;

   // Reads are held back on the registered count only, so a same-cycle pop never frees a slot
   assign w_cand0 = (s0_read | s0_write) & ~(s0_read & w_fifo_full);
   assign w_cand1 = (s1_read | s1_write) & ~(s1_read & w_fifo_full);

   always_comb begin
      w_sel     = PORT_S0;
      w_present = 1'b0;
      if (r_state == ST_LOCKED) begin
         w_sel     = r_owner;
         w_present = (r_owner == PORT_S1) ? w_cand1 : w_cand0;
      end else if (w_cand0 && w_cand1) begin
         w_sel     = r_prio;
         w_present = 1'b1;
      end else if (w_cand1) begin
         w_sel     = PORT_S1;
         w_present = 1'b1;
      end else if (w_cand0) begin
         w_sel     = PORT_S0;
         w_present = 1'b1;
      end
   end

   assign w_go     = w_present & rest;
   assign w_accept = w_go & ~m0_waitRequest;
   assign w_stall  = w_go &  m0_waitRequest;
   assign w_push   = w_accept & m0_read;
   assign w_pop    = m0_readDataValid & ~w_fifo_empty & rest;

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         r_state <= ST_UNLOCKED;
         r_owner <= PORT_S0;
         r_prio  <= PORT_S0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_prio  <= w_prio_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_prio_nxt  = r_prio;
      if (w_accept) begin
         w_state_nxt = ST_UNLOCKED;
         w_prio_nxt  = ~w_sel;
      end else if (w_stall) begin
         w_state_nxt = ST_LOCKED;
         w_owner_nxt = w_sel;
      end
   end

   always_comb begin
      m0_address       = '0;
      m0_byteEnable    = '0;
      m0_read          = 1'b0;
      m0_write         = 1'b0;
      m0_writeData     = '0;
      s0_waitRequest   = 1'b1;
      s1_waitRequest   = 1'b1;
      s0_readDataValid = 1'b0;
      s1_readDataValid = 1'b0;
      if (w_go) begin
         if (w_sel == PORT_S1) begin
            m0_address    = s1_address;
            m0_byteEnable = s1_byteEnable;
            m0_read       = s1_read;
            m0_write      = s1_write;
            m0_writeData  = s1_writeData;
         end else begin
            m0_address    = s0_address;
            m0_byteEnable = s0_byteEnable;
            m0_read       = s0_read;
            m0_write      = s0_write;
            m0_writeData  = s0_writeData;
         end
      end
      if (w_accept) begin
         if (w_sel == PORT_S1) s1_waitRequest = 1'b0;
         else                  s0_waitRequest = 1'b0;
      end
      if (w_pop) begin
         if (w_fifo_head == PORT_S1) s1_readDataValid = 1'b1;
         else                        s0_readDataValid = 1'b1;
      end
   end

   assign s0_readData = m0_readData;
   assign s1_readData = m0_readData;

   cache_arb_id_fifo #(
      .DEPTH (MAX_PENDING)
   ) u_id_fifo (
      .clk     (clk),
      .rest    (rest),
      .i_push  (w_push),
      .i_id    (w_sel),
      .i_pop   (w_pop),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_head  (w_fifo_head)
   );

endmodule

// File: tb/tb_cache_bus_arb.sv
// tb/tb_cache_bus_arb.sv - self-checking bench for cache_bus_arb against a queue-based reference model
module tb_cache_bus_arb;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MP = 4;

   logic          clk = 1'b0;
   logic          rest;
   logic [AW-1:0] s0_address, s1_address, m0_address;
   logic [BW-1:0] s0_byteEnable, s1_byteEnable, m0_byteEnable;
   logic          s0_read, s0_write, s1_read, s1_write, m0_read, m0_write;
   logic [DW-1:0] s0_writeData, s1_writeData, m0_writeData;
   logic          s0_waitRequest, s1_waitRequest, m0_waitRequest;
   logic [DW-1:0] s0_readData, s1_readData, m0_readData;
   logic          s0_readDataValid, s1_readDataValid, m0_readDataValid;

   always #5 clk = ~clk;

   cache_bus_arb #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .MAX_PENDING (MP)
   ) dut (
      .clk              (clk),
      .rest             (rest),
      .s0_address       (s0_address),
      .s0_byteEnable    (s0_byteEnable),
      .s0_read          (s0_read),
      .s0_write         (s0_write),
      .s0_writeData     (s0_writeData),
      .s0_waitRequest   (s0_waitRequest),
      .s0_readData      (s0_readData),
      .s0_readDataValid (s0_readDataValid),
      .s1_address       (s1_address),
      .s1_byteEnable    (s1_byteEnable),
      .s1_read          (s1_read),
      .s1_write         (s1_write),
      .s1_writeData     (s1_writeData),
      .s1_waitRequest   (s1_waitRequest),
      .s1_readData      (s1_readData),
      .s1_readDataValid (s1_readDataValid),
      .m0_address       (m0_address),
      .m0_byteEnable    (m0_byteEnable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writeData     (m0_writeData),
      .m0_waitRequest   (m0_waitRequest),
      .m0_readData      (m0_readData),
      .m0_readDataValid (m0_readDataValid)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Requester side: each port holds its command until it sees waitRequest low
   bit            p_act [2];
   bit            p_rd  [2];
   logic [AW-1:0] p_addr[2];
   logic [DW-1:0] p_data[2];
   logic [BW-1:0] p_be  [2];

   // Memory side stimulus
   bit            mw;
   bit            mrv;
   logic [DW-1:0] mrd;

   // Reference model: arbitration rules plus an issue-order queue of port IDs
   bit m_lock, m_owner, m_prio;
   bit q[$];

   logic          last_rd, last_wr;
   logic          last_w[2];
   logic          last_v[2];
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_wdata;
   int            g_log[$];
   int            v_log[$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic set_cmd(input int i, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
      p_act[i]  = 1'b1;
      p_rd[i]   = rd;
      p_addr[i] = a;
      p_data[i] = d;
      p_be[i]   = BW'($urandom);
   endtask

   task automatic apply();
      s0_read          = p_act[0] &  p_rd[0];
      s0_write         = p_act[0] & ~p_rd[0];
      s0_address       = p_addr[0];
      s0_writeData     = p_data[0];
      s0_byteEnable    = p_be[0];
      s1_read          = p_act[1] &  p_rd[1];
      s1_write         = p_act[1] & ~p_rd[1];
      s1_address       = p_addr[1];
      s1_writeData     = p_data[1];
      s1_byteEnable    = p_be[1];
      m0_waitRequest   = mw;
      m0_readDataValid = mrv;
      m0_readData      = mrd;
   endtask

   task automatic model_reset();
      m_lock  = 1'b0;
      m_owner = 1'b0;
      m_prio  = 1'b0;
      q.delete();
      p_act[0] = 1'b0;
      p_act[1] = 1'b0;
   endtask

   // One clock: drive after posedge, check at negedge, advance the model at posedge
   task automatic step();
      bit cand[2];
      bit pres, sel, acc, pop, hid;
      apply();
      @(negedge clk);
      for (int i = 0; i < 2; i++)
         cand[i] = p_act[i] && !(p_rd[i] && q.size() == MP);
      pres = 1'b0;
      sel  = 1'b0;
      if (m_lock) begin
         sel  = m_owner;
         pres = cand[m_owner];
      end else if (cand[0] && cand[1]) begin
         sel  = m_prio;
         pres = 1'b1;
      end else if (cand[0] || cand[1]) begin
         sel  = cand[1];
         pres = 1'b1;
      end
      acc = pres && !mw;
      pop = mrv && q.size() > 0;
      hid = (q.size() > 0) ? q[0] : 1'b0;

      check_eq("m0_read",  64'(m0_read),  64'(pres && p_rd[sel]));
      check_eq("m0_write", 64'(m0_write), 64'(pres && !p_rd[sel]));
      if (pres) begin
         check_eq("m0_address", 64'(m0_address),    64'(p_addr[sel]));
         check_eq("m0_be",      64'(m0_byteEnable), 64'(p_be[sel]));
         if (!p_rd[sel]) check_eq("m0_writeData", 64'(m0_writeData), 64'(p_data[sel]));
      end
      check_eq("s0_waitRequest",   64'(s0_waitRequest),   64'(!(acc && sel == 1'b0)));
      check_eq("s1_waitRequest",   64'(s1_waitRequest),   64'(!(acc && sel == 1'b1)));
      check_eq("s0_readDataValid", 64'(s0_readDataValid), 64'(pop && hid == 1'b0));
      check_eq("s1_readDataValid", 64'(s1_readDataValid), 64'(pop && hid == 1'b1));
      if (pop) check_eq("readData", 64'(hid ? s1_readData : s0_readData), 64'(mrd));

      last_rd    = m0_read;
      last_wr    = m0_write;
      last_addr  = m0_address;
      last_wdata = m0_writeData;
      last_w[0]  = s0_waitRequest;
      last_w[1]  = s1_waitRequest;
      last_v[0]  = s0_readDataValid;
      last_v[1]  = s1_readDataValid;
      if (!s0_waitRequest) g_log.push_back(0);
      if (!s1_waitRequest) g_log.push_back(1);
      if (s0_readDataValid) v_log.push_back(0);
      if (s1_readDataValid) v_log.push_back(1);

      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (acc) begin
         m_prio = !sel;
         m_lock = 1'b0;
         if (p_rd[sel]) q.push_back(sel);
      end else if (pres) begin
         m_lock  = 1'b1;
         m_owner = sel;
      end
      #1;
      if (acc) p_act[sel] = 1'b0;
   endtask

   task automatic do_reset();
      rest = 1'b0;
      model_reset();
      mw  = 1'b0;
      mrv = 1'b0;
      apply();
      repeat (2) @(posedge clk);
      #1;
      rest = 1'b1;
   endtask

   initial begin
      int exp_g[4];
      int exp_v[4];
      rest = 1'b0;
      mrd  = '0;
      model_reset();
      mw  = 1'b0;
      mrv = 1'b1;
      set_cmd(0, 1'b1, 32'h40, 32'h0);
      apply();
      #2;
      check_eq("rst_m0_read",  64'(m0_read),          64'(0));
      check_eq("rst_m0_write", 64'(m0_write),         64'(0));
      check_eq("rst_s0_wait",  64'(s0_waitRequest),   64'(1));
      check_eq("rst_s1_wait",  64'(s1_waitRequest),   64'(1));
      check_eq("rst_s0_valid", 64'(s0_readDataValid), 64'(0));
      do_reset();

      // Lone read, then its return
      set_cmd(0, 1'b1, 32'h100, 32'h0);
      step();
      check_eq("t1_read", 64'(last_rd),   64'(1));
      check_eq("t1_addr", 64'(last_addr), 64'(32'h100));
      mrv = 1'b1;
      mrd = 32'hDEAD;
      step();
      mrv = 1'b0;
      check_eq("t1_v0", 64'(last_v[0]), 64'(1));
      check_eq("t1_v1", 64'(last_v[1]), 64'(0));

      // Contention right after reset alternates starting with s0
      do_reset();
      g_log.delete();
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 2; i++)
            if (!p_act[i]) set_cmd(i, 1'b0, 32'h200 + 32'(i), 32'($urandom));
         step();
      end
      exp_g = '{0, 1, 0, 1};
      check_eq("t2_grant_count", 64'(g_log.size()), 64'(4));
      for (int k = 0; k < 4 && k < g_log.size(); k++)
         check_eq($sformatf("t2_grant%0d", k), 64'(g_log[k]), 64'(exp_g[k]));
      p_act[0] = 1'b0;
      p_act[1] = 1'b0;

      // s1 write stalled three cycles holds the bus against s0
      set_cmd(1, 1'b0, 32'h3000, 32'hCAFE_F00D);
      for (int k = 0; k < 4; k++) begin
         mw = (k < 3);
         if (k == 1) set_cmd(0, 1'b0, 32'h3004, 32'h1111_2222);
         step();
         check_eq($sformatf("t3_addr%0d", k),  64'(last_addr),  64'(32'h3000));
         check_eq($sformatf("t3_wdata%0d", k), 64'(last_wdata), 64'(32'hCAFE_F00D));
         check_eq($sformatf("t3_w0_%0d", k),   64'(last_w[0]),  64'(1));
      end
      check_eq("t3_s1_acc", 64'(last_w[1]), 64'(0));
      mw = 1'b0;
      step();
      check_eq("t3_s0_acc", 64'(last_w[0]), 64'(0));

      // Interleaved reads return in issue order
      v_log.delete();
      set_cmd(0, 1'b1, 32'h400, 0); step();
      set_cmd(1, 1'b1, 32'h404, 0); step();
      set_cmd(1, 1'b1, 32'h408, 0); step();
      set_cmd(0, 1'b1, 32'h40C, 0); step();
      for (int k = 0; k < 8; k++) begin
         mrv = k[0];
         mrd = 32'hD000 + 32'(k);
         step();
      end
      mrv = 1'b0;
      exp_v = '{0, 1, 1, 0};
      check_eq("t4_ret_count", 64'(v_log.size()), 64'(4));
      for (int k = 0; k < 4 && k < v_log.size(); k++)
         check_eq($sformatf("t4_ret%0d", k), 64'(v_log[k]), 64'(exp_v[k]));

      // Full FIFO blocks reads but not writes; a pop frees the slot one cycle later
      for (int k = 0; k < MP; k++) begin
         set_cmd(0, 1'b1, 32'h500 + 32'(4 * k), 0);
         step();
      end
      set_cmd(0, 1'b1, 32'h5F0, 0);
      set_cmd(1, 1'b0, 32'h5F4, 32'h7777);
      step();
      check_eq("t5_rd_held", 64'(last_rd),   64'(0));
      check_eq("t5_wr_go",   64'(last_wr),   64'(1));
      check_eq("t5_s1_acc",  64'(last_w[1]), 64'(0));
      mrv = 1'b1;
      step();
      check_eq("t5_rd_same_cycle", 64'(last_rd),   64'(0));
      check_eq("t5_pop_v0",        64'(last_v[0]), 64'(1));
      mrv = 1'b0;
      step();
      check_eq("t5_rd_next", 64'(last_rd),   64'(1));
      check_eq("t5_s0_acc",  64'(last_w[0]), 64'(0));
      mrv = 1'b1;
      repeat (MP) step();
      mrv = 1'b0;

      // Reset with two reads pending and a stalled lock
      set_cmd(0, 1'b1, 32'h600, 0); step();
      set_cmd(1, 1'b1, 32'h604, 0); step();
      set_cmd(0, 1'b0, 32'h608, 32'h55); mw = 1'b1; step();
      set_cmd(1, 1'b0, 32'h60C, 32'h66);
      mrv  = 1'b1;
      apply();
      rest = 1'b0;
      #1;
      check_eq("t6_m0_read",  64'(m0_read),          64'(0));
      check_eq("t6_m0_write", 64'(m0_write),         64'(0));
      check_eq("t6_s0_wait",  64'(s0_waitRequest),   64'(1));
      check_eq("t6_s1_wait",  64'(s1_waitRequest),   64'(1));
      check_eq("t6_s0_valid", 64'(s0_readDataValid), 64'(0));
      check_eq("t6_s1_valid", 64'(s1_readDataValid), 64'(0));
      model_reset();
      mw = 1'b0;
      apply();
      repeat (2) @(posedge clk);
      #1;
      rest = 1'b1;
      step();
      check_eq("t6_drop_v0", 64'(last_v[0]), 64'(0));
      check_eq("t6_drop_v1", 64'(last_v[1]), 64'(0));
      mrv = 1'b0;
      set_cmd(0, 1'b0, 32'h700, 32'hA0);
      set_cmd(1, 1'b0, 32'h704, 32'hA1);
      step();
      check_eq("t6_first_s0", 64'(last_w[0]), 64'(0));
      check_eq("t6_first_s1", 64'(last_w[1]), 64'(1));

      // Randomized traffic: fast returns, then slow returns to fill the FIFO
      for (int ph = 0; ph < 2; ph++) begin
         for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 2; i++)
               if (!p_act[i] && $urandom_range(99) < 60)
                  set_cmd(i, 1'($urandom_range(1)), 32'($urandom), 32'($urandom));
            mw  = ($urandom_range(99) < 30);
            mrv = (q.size() > 0) ? ($urandom_range(99) < (ph == 0 ? 50 : 12))
                                 : ($urandom_range(99) < 5);
            mrd = 32'($urandom);
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
